// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining 8N1 UART transmitter:
// FSM state encoding and frame shape constants.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between the byte FIFO and its single reader.
// master = the transmitter (pops bytes), slave = the FIFO.
interface fifo_uart_tx_if;

  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_ren;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_ren
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_ren
  );

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLK_DIV-1 and wraps, flagging the last
// count of each period. Held at zero while clear is high.
module bit_timer #(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 16
) (
  input  logic ck,
  input  logic rst,
  input  logic clear,
  output logic period_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Period counter with explicit compare-and-clear at the last count.
  always_ff @(posedge ck) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE_CNT;
    end
  end

  assign period_done = (cnt_r == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that pops one byte at a time from the upstream
// FIFO and shifts it out LSB first. All outputs come straight from flops;
// they are loaded from the decode of the next state so that they line up
// with the state they belong to.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 16
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fif,
  output logic                  txd,
  output logic                  busy
);

  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

  tx_state_e  state_r;
  tx_state_e  state_next_s;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_next_s;
  logic [7:0] shift_r;
  logic [7:0] shift_next_s;
  logic       txd_r;
  logic       txd_next_s;
  logic       fifo_ren_r;
  logic       fifo_ren_next_s;
  logic       busy_r;
  logic       busy_next_s;
  logic       timer_clear_s;
  logic       period_done_s;

  // The bit timer only runs while a frame is on the line.
  assign timer_clear_s = (state_r == IDLE) || (state_r == REQ) || (state_r == LOAD);

  bit_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_bit_timer (
    .ck          (ck),
    .rst         (rst),
    .clear       (timer_clear_s),
    .period_done (period_done_s)
  );

  // Next-state and datapath update: request, load, then start/data/stop bits.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    case (state_r)
      IDLE: begin
        if (tx_en && !fif.fifo_empty) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        // The FIFO cannot go empty without a read, so no re-check here.
        state_next_s = LOAD;
      end
      LOAD: begin
        shift_next_s   = fif.fifo_dout;
        bit_cnt_next_s = 3'd0;
        state_next_s   = START;
      end
      START: begin
        if (period_done_s) begin
          bit_cnt_next_s = 3'd0;
          state_next_s   = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (period_done_s) begin
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_cnt_r == LAST_DATA_BIT) begin
            bit_cnt_next_s = 3'd0;
            state_next_s   = STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
            state_next_s   = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (period_done_s) begin
          if (bit_cnt_r == LAST_STOP_BIT) begin
            bit_cnt_next_s = 3'd0;
            state_next_s   = IDLE;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
            state_next_s   = STOP;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s   = IDLE;
        bit_cnt_next_s = 3'd0;
        shift_next_s   = 8'h00;
      end
    endcase
  end

  // Output values for the state about to be entered.
  always_comb begin
    txd_next_s      = 1'b1;
    fifo_ren_next_s = 1'b0;
    busy_next_s     = 1'b1;
    case (state_next_s)
      IDLE:    busy_next_s     = 1'b0;
      REQ:     fifo_ren_next_s = 1'b1;
      LOAD:    txd_next_s      = 1'b1;
      START:   txd_next_s      = 1'b0;
      DATA:    txd_next_s      = shift_next_s[0];
      STOP:    txd_next_s      = 1'b1;
      default: busy_next_s     = 1'b0;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge ck) begin
    if (!rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      txd_r      <= 1'b1;
      fifo_ren_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      txd_r      <= txd_next_s;
      fifo_ren_r <= fifo_ren_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign txd          = txd_r;
  assign busy         = busy_r;
  assign fif.fifo_ren = fifo_ren_r;

endmodule
